cpu_debug_probe: RTL and testbench
==================================

Name: cpu_debug_probe

Overview:
- Parametrised observation port for the CPU pipeline, successor to the single select/out_data debug output.
- Selects one of NUM_CH internal DATA_W-bit probe channels and drives one registered debug output.
- Three modes:
  - LIVE: manual select.
  - SCAN: automatic rotation through all channels with a fixed dwell.
  - SNAP: trigger-armed one-shot capture, held until the mode changes.
- Sits at the top of the CPU, between the pipeline probe taps and the out_data pin.

Parameters:
DATA_W, 32, width of each probe channel and of out_data
NUM_CH, 4, number of probe channels (>=2, need not be a power of two)
DWELL, 20, cycles each channel is shown in SCAN mode (>=1)
SEL_W, $clog2(NUM_CH), localparam, channel index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
ch_data  in  NUM_CH*DATA_W  packed channels; channel i at [i*DATA_W +: DATA_W]
ch_sel  in  SEL_W  channel select for LIVE and SNAP
mode  in  2  00 LIVE, 01 SCAN, 10 SNAP, 11 reserved (treated as LIVE)
trig  in  1  snapshot trigger, level-sampled each cycle
out_data  out  DATA_W  registered probe output
out_ch  out  SEL_W  channel index currently shown in out_data
out_valid  out  1  out_data holds meaningful data
snap_done  out  1  capture completed in SNAP mode
change_cnt  out  16  count of out_data value changes while valid, saturating

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - reset is synchronous and active-high.
  - While reset=1 at a rising edge: state=IDLE; out_data=0, out_ch=0, out_valid=0, snap_done=0, change_cnt=0; dwell counter=0, scan_ch=0.
- States: IDLE, LIVE, SCAN, ARMED, HELD.
- From IDLE: one cycle after reset release, go to LIVE, SCAN or ARMED according to mode.
- Mode change: whenever mode differs from the value registered last cycle (any state), the next state is that mode's entry state (LIVE / SCAN / ARMED).
  - SCAN entry: scan_ch=0, dwell=0.
  - Any mode change clears snap_done.
- Output timing: all outputs are registered. Inputs sampled at edge k appear on outputs after edge k (1-cycle latency).
- LIVE:
  - out_data <= ch_data[ch_sel]; out_ch <= ch_sel; out_valid <= 1.
  - ch_sel >= NUM_CH selects channel 0 and reports out_ch=0.
- SCAN:
  - out_data <= ch_data[scan_ch]; out_ch <= scan_ch; out_valid <= 1.
  - dwell increments each cycle. At dwell==DWELL-1: dwell wraps to 0 and scan_ch increments.
  - scan_ch wraps from NUM_CH-1 to 0.
  - DWELL=1 advances the channel every cycle.
- ARMED:
  - out_valid <= 0; out_data and out_ch hold.
  - trig=1: capture ch_data[ch_sel] (same range rule as LIVE) into out_data; out_ch <= sel; out_valid <= 1; snap_done <= 1; go to HELD.
- HELD:
  - All outputs hold; trig is ignored.
  - Leaving HELD is possible only by a mode change or reset.
- change_cnt:
  - Increments by 1 on an edge where the new out_valid=1, the previous out_valid=1, and the new out_data != previous out_data.
  - Saturates at 16'hFFFF.
  - Cleared only by reset; never cleared by a mode change.
- Reset mid-operation (any state) overrides all other activity in the same cycle.
- A mode change and trig in the same cycle: the mode change wins and the trig is dropped.

Decomposition:
- Package cpu_dbg_pkg:
  - mode_e enum (MODE_LIVE, MODE_SCAN, MODE_SNAP, MODE_RSVD)
  - state_e enum (S_IDLE, S_LIVE, S_SCAN, S_ARMED, S_HELD)
  - CNT_W=16, CNT_MAX
- Sub-module dbg_scan_timer:
  - Dwell counter plus channel rotator (parameters NUM_CH, DWELL).
  - Inputs: clk, reset, restart, enable.
  - Output: scan_ch.
- The top module holds the FSM, channel mux, output registers and change counter.

Test Plan:
1. Reset held 3 cycles, mode=LIVE, channels nonzero -> all outputs 0 during reset and at the first edge after release; out_valid=1 and out_data=ch0 value after the second edge.
2. LIVE, ch_data={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, ch_sel=2 -> out_data=0xCCCC0002, out_ch=2 one cycle later. ch_sel->1 -> 0xBBBB0001 next cycle; change_cnt=1.
3. Instance NUM_CH=3, DWELL=4, mode=SCAN -> out_ch sequence 0,0,0,0,1,1,1,1,2,2,2,2,0 with matching out_data.
4. SNAP: out_valid=0 while ARMED. trig with ch0=0x12345678, ch_sel=0 -> out_data=0x12345678, snap_done=1. Then ch0->0xFFFFFFFF plus another trig -> outputs unchanged.
5. Cases:
   - HELD, switch to LIVE -> snap_done=0 and live data next cycle.
   - SCAN at out_ch=2, assert reset 1 cycle -> outputs zero; scan restarts at ch0.
   - Mode change with simultaneous trig -> no capture.
6. LIVE, alternate ch_sel between two differing channels every cycle for 70000 cycles -> change_cnt stops at 0xFFFF; a mode change afterwards does not clear it.

Source files
------------

// File: rtl/cpu_debug_probe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared types and constants for the CPU debug probe: the mode encoding on the
// mode pin, the controller state set, the change-counter width and a helper
// that maps a mode to the state the controller enters when that mode is
// selected.
// ---------------------------------------------------------------------------
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE = 2'b00,
        MODE_SCAN = 2'b01,
        MODE_SNAP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIVE,
        S_SCAN,
        S_ARMED,
        S_HELD
    } state_e;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The reserved encoding behaves exactly like LIVE.
    function automatic state_e entry_state(input mode_e m);
        case (m)
            MODE_SCAN: return S_SCAN;
            MODE_SNAP: return S_ARMED;
            default:   return S_LIVE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_debug_probe_if.sv
// ---------------------------------------------------------------------------
// cpu_debug_probe_if
// Bundles the probe taps, the control inputs and the registered debug outputs.
//   ch_data    packed probe channels, channel i at [i*DATA_W +: DATA_W]
//   ch_sel     channel select for LIVE and SNAP
//   mode       00 LIVE, 01 SCAN, 10 SNAP, 11 reserved (LIVE)
//   trig       snapshot trigger
//   out_data   registered probe output
//   out_ch     channel index shown in out_data
//   out_valid  out_data is meaningful
//   snap_done  SNAP capture completed
//   change_cnt saturating count of out_data changes while valid
// master: the side driving taps/controls; slave: the probe itself.
// ---------------------------------------------------------------------------
interface cpu_debug_probe_if
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [SEL_W-1:0]         ch_sel;
    logic [1:0]               mode;
    logic                     trig;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     snap_done;
    logic [CNT_W-1:0]         change_cnt;

    modport master (
        output ch_data, ch_sel, mode, trig,
        input  out_data, out_ch, out_valid, snap_done, change_cnt
    );

    modport slave (
        input  ch_data, ch_sel, mode, trig,
        output out_data, out_ch, out_valid, snap_done, change_cnt
    );

endinterface

// File: rtl/cpu_debug_probe_scan_timer.sv
// ---------------------------------------------------------------------------
// dbg_scan_timer
// Dwell counter plus channel rotator for SCAN mode. Each channel is held for
// DWELL enabled cycles, then the rotator steps, wrapping after NUM_CH-1.
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   restart  return to channel 0 with a fresh dwell (takes priority)
//   enable   advance the dwell count this cycle
//   scan_ch  channel currently selected by the rotation
// ---------------------------------------------------------------------------
module dbg_scan_timer #(
    parameter int NUM_CH = 4,
    parameter int DWELL  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      restart,
    input  logic                      enable,
    output logic [$clog2(NUM_CH)-1:0] scan_ch
);
    localparam int SEL_W = $clog2(NUM_CH);
    // DWELL=1 still needs a 1-bit counter; it simply sits at 0 and wraps every cycle.
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [DW_W-1:0]  r_dwell;
    logic [SEL_W-1:0] r_scan_ch;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_dwell   <= '0;
            r_scan_ch <= '0;
        end else if (enable) begin
            if (r_dwell == DW_W'(DWELL - 1)) begin
                r_dwell   <= '0;
                r_scan_ch <= (r_scan_ch == SEL_W'(NUM_CH - 1)) ? '0 : r_scan_ch + SEL_W'(1);
            end else begin
                r_dwell <= r_dwell + DW_W'(1);
            end
        end
    end

    assign scan_ch = r_scan_ch;

endmodule

// File: rtl/cpu_debug_probe.sv
// ---------------------------------------------------------------------------
// cpu_debug_probe
// Selects one of NUM_CH probe channels onto a registered debug output, with
// manual (LIVE), rotating (SCAN) and trigger-armed one-shot (SNAP) modes.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   dbg    cpu_debug_probe_if.slave (taps, controls, registered outputs)
//
// state   | meaning
// S_IDLE  | first cycle after reset, outputs still cleared
// S_LIVE  | out_data follows ch_data[ch_sel]
// S_SCAN  | out_data follows the rotating scan channel
// S_ARMED | output invalid, waiting for trig
// S_HELD  | snapshot captured, everything frozen until a mode change
// ---------------------------------------------------------------------------
module cpu_debug_probe
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int DWELL  = 20
) (
    input  logic              clk,
    input  logic              reset,
    cpu_debug_probe_if.slave  dbg
);
    localparam int SEL_W = $clog2(NUM_CH);

    state_e            r_state;
    state_e            w_state_nx;
    logic [1:0]        r_mode;
    logic              w_mode_chg;
    logic              w_restart;
    logic              w_scan_en;
    logic [SEL_W-1:0]  w_sel;
    logic [SEL_W-1:0]  w_scan_ch;
    logic [DATA_W-1:0] w_ch [NUM_CH];

    logic [DATA_W-1:0] r_out_data,  w_out_data_nx;
    logic [SEL_W-1:0]  r_out_ch,    w_out_ch_nx;
    logic              r_out_valid, w_out_valid_nx;
    logic              r_snap_done, w_snap_done_nx;
    logic [CNT_W-1:0]  r_change_cnt, w_change_cnt_nx;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_ch[gi] = dbg.ch_data[gi*DATA_W +: DATA_W];
    end

    // Out-of-range selects fall back to channel 0.
    assign w_sel      = (int'(dbg.ch_sel) < NUM_CH) ? dbg.ch_sel : '0;
    assign w_mode_chg = (dbg.mode != r_mode);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
        r_mode <= dbg.mode;
    end

    // Next state; a mode change beats a trigger in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        if (r_state == S_IDLE || w_mode_chg) begin
            w_state_nx = entry_state(mode_e'(dbg.mode));
        end else if (r_state == S_ARMED && dbg.trig) begin
            w_state_nx = S_HELD;
        end
    end

    assign w_restart = (r_state == S_IDLE || w_mode_chg) && (w_state_nx == S_SCAN);
    assign w_scan_en = (r_state == S_SCAN) && !w_restart;

    dbg_scan_timer #(
        .NUM_CH (NUM_CH),
        .DWELL  (DWELL)
    ) u_scan_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .enable  (w_scan_en),
        .scan_ch (w_scan_ch)
    );

    // Output values for the coming edge, driven by the current state.
    always_comb begin
        w_out_data_nx   = r_out_data;
        w_out_ch_nx     = r_out_ch;
        w_out_valid_nx  = r_out_valid;
        w_snap_done_nx  = r_snap_done;
        w_change_cnt_nx = r_change_cnt;
        case (r_state)
            S_LIVE: begin
                w_out_data_nx  = w_ch[w_sel];
                w_out_ch_nx    = w_sel;
                w_out_valid_nx = 1'b1;
            end
            S_SCAN: begin
                w_out_data_nx  = w_ch[w_scan_ch];
                w_out_ch_nx    = w_scan_ch;
                w_out_valid_nx = 1'b1;
            end
            S_ARMED: begin
                if (dbg.trig && !w_mode_chg) begin
                    w_out_data_nx  = w_ch[w_sel];
                    w_out_ch_nx    = w_sel;
                    w_out_valid_nx = 1'b1;
                    w_snap_done_nx = 1'b1;
                end else begin
                    w_out_valid_nx = 1'b0;
                end
            end
            default: ;
        endcase
        if (w_mode_chg) begin
            w_snap_done_nx = 1'b0;
        end
        if (w_out_valid_nx && r_out_valid && (w_out_data_nx != r_out_data)
            && (r_change_cnt != CNT_MAX)) begin
            w_change_cnt_nx = r_change_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_valid  <= 1'b0;
            r_snap_done  <= 1'b0;
            r_change_cnt <= '0;
        end else begin
            r_out_data   <= w_out_data_nx;
            r_out_ch     <= w_out_ch_nx;
            r_out_valid  <= w_out_valid_nx;
            r_snap_done  <= w_snap_done_nx;
            r_change_cnt <= w_change_cnt_nx;
        end
    end

    assign dbg.out_data   = r_out_data;
    assign dbg.out_ch     = r_out_ch;
    assign dbg.out_valid  = r_out_valid;
    assign dbg.snap_done  = r_snap_done;
    assign dbg.change_cnt = r_change_cnt;

endmodule

// File: tb/tb_cpu_debug_probe.sv
// ---------------------------------------------------------------------------
// tb_cpu_debug_probe
// Two probe instances: A (4 channels, dwell 20) for LIVE/SNAP/saturation and
// B (3 channels, dwell 4) for short scan rotations and randomized LIVE traffic.
// ---------------------------------------------------------------------------
module tb_cpu_debug_probe;
    import cpu_dbg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;

    cpu_debug_probe_if #(.DATA_W(32), .NUM_CH(4)) if_a ();
    cpu_debug_probe_if #(.DATA_W(32), .NUM_CH(3)) if_b ();

    cpu_debug_probe #(.DATA_W(32), .NUM_CH(4), .DWELL(20)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .dbg   (if_a.slave)
    );

    cpu_debug_probe #(.DATA_W(32), .NUM_CH(3), .DWELL(4)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .dbg   (if_b.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state for instance B's change counter.
    int unsigned m_cnt;
    logic        m_prev_valid;
    logic [31:0] m_prev_data;
    logic [31:0] chv [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic b_model_reset();
        m_cnt        = 0;
        m_prev_valid = 1'b0;
        m_prev_data  = '0;
    endtask

    // A change is counted when two consecutive valid outputs differ.
    task automatic b_model(input logic v, input logic [31:0] d);
        if (v && m_prev_valid && d != m_prev_data && m_cnt < 32'd65535) m_cnt++;
        m_prev_valid = v;
        m_prev_data  = d;
    endtask

    task automatic a_rand();
        for (int i = 0; i < 4; i++) begin
            chv[i] = $urandom;
            if_a.ch_data[i*32 +: 32] = chv[i];
        end
    endtask

    task automatic b_rand();
        for (int i = 0; i < 3; i++) begin
            chv[i] = $urandom;
            if_b.ch_data[i*32 +: 32] = chv[i];
        end
    endtask

    // Channel shown on the n-th edge after SCAN entry.
    function automatic int scan_at(input int n, input int dwell, input int nch);
        return ((n - 1) / dwell) % nch;
    endfunction

    initial begin
        int e;
        int s;

        reset_a = 1'b1;
        reset_b = 1'b1;
        if_a.mode    = 2'b00;
        if_a.ch_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        if_a.ch_sel  = 2'd0;
        if_a.trig    = 1'b0;
        if_b.mode    = 2'b01;
        if_b.ch_data = '0;
        if_b.ch_sel  = 2'd0;
        if_b.trig    = 1'b0;

        // Reset and release
        step();
        chk("rst_data", if_a.out_data, 0);
        chk("rst_valid", if_a.out_valid, 0);
        step();
        step();
        chk("rst_ch", if_a.out_ch, 0);
        chk("rst_snap", if_a.snap_done, 0);
        chk("rst_cnt", if_a.change_cnt, 0);
        reset_a = 1'b0;
        step();
        chk("idle_valid", if_a.out_valid, 0);
        chk("idle_data", if_a.out_data, 0);
        step();
        chk("live0_valid", if_a.out_valid, 1);
        chk("live0_data", if_a.out_data, 32'hAAAA0000);
        chk("live0_ch", if_a.out_ch, 0);
        chk("live0_cnt", if_a.change_cnt, 0);

        // LIVE selection
        if_a.ch_sel = 2'd2;
        step();
        chk("live2_data", if_a.out_data, 32'hCCCC0002);
        chk("live2_ch", if_a.out_ch, 2);
        chk("live2_cnt", if_a.change_cnt, 1);
        if_a.ch_sel = 2'd1;
        step();
        chk("live1_data", if_a.out_data, 32'hBBBB0001);
        chk("live1_ch", if_a.out_ch, 1);
        chk("live1_cnt", if_a.change_cnt, 2);

        // SNAP: change edge still shows live data, then ARMED
        if_a.ch_data[31:0] = 32'h0BAD0000;
        if_a.ch_sel = 2'd0;
        if_a.mode   = 2'b10;
        step();
        chk("snapchg_data", if_a.out_data, 32'h0BAD0000);
        chk("snapchg_cnt", if_a.change_cnt, 3);
        step();
        chk("armed_valid", if_a.out_valid, 0);
        chk("armed_snap", if_a.snap_done, 0);
        chk("armed_hold", if_a.out_data, 32'h0BAD0000);
        step();
        chk("armed_valid2", if_a.out_valid, 0);
        if_a.ch_data[31:0] = 32'h12345678;
        if_a.trig = 1'b1;
        step();
        chk("cap_data", if_a.out_data, 32'h12345678);
        chk("cap_valid", if_a.out_valid, 1);
        chk("cap_snap", if_a.snap_done, 1);
        chk("cap_ch", if_a.out_ch, 0);
        chk("cap_cnt", if_a.change_cnt, 3);
        if_a.ch_data[31:0] = 32'hFFFFFFFF;
        step();
        chk("held_data", if_a.out_data, 32'h12345678);
        chk("held_snap", if_a.snap_done, 1);
        if_a.trig = 1'b0;
        step();
        chk("held_data2", if_a.out_data, 32'h12345678);
        chk("held_valid", if_a.out_valid, 1);

        // HELD -> LIVE
        if_a.mode   = 2'b00;
        if_a.ch_sel = 2'd2;
        step();
        chk("unheld_snap", if_a.snap_done, 0);
        chk("unheld_hold", if_a.out_data, 32'h12345678);
        step();
        chk("unheld_live", if_a.out_data, 32'hCCCC0002);
        chk("unheld_ch", if_a.out_ch, 2);
        chk("unheld_cnt", if_a.change_cnt, 4);

        // Mode change with trig in the same cycle: no capture
        if_a.mode   = 2'b10;
        if_a.trig   = 1'b1;
        if_a.ch_sel = 2'd1;
        step();
        chk("chgtrig_data", if_a.out_data, 32'hBBBB0001);
        chk("chgtrig_snap", if_a.snap_done, 0);
        chk("chgtrig_cnt", if_a.change_cnt, 5);
        if_a.trig = 1'b0;
        step();
        chk("chgtrig_valid", if_a.out_valid, 0);
        chk("chgtrig_snap2", if_a.snap_done, 0);

        // Saturation of change_cnt
        if_a.mode = 2'b00;
        for (int k = 0; k < 65600; k++) begin
            if_a.ch_sel = 2'(k % 2);
            step();
        end
        chk("sat_cnt", if_a.change_cnt, 16'hFFFF);
        chk("sat_valid", if_a.out_valid, 1);
        if_a.mode = 2'b01;
        step();
        chk("sat_keep", if_a.change_cnt, 16'hFFFF);

        // SCAN on A with randomized channel contents
        for (int n = 1; n <= 90; n++) begin
            a_rand();
            step();
            e = scan_at(n, 20, 4);
            chk("a_scan_ch", if_a.out_ch, e);
            chk("a_scan_data", if_a.out_data, chv[e]);
        end
        chk("a_scan_cnt", if_a.change_cnt, 16'hFFFF);

        // SCAN on B: NUM_CH=3, DWELL=4
        reset_b = 1'b0;
        b_model_reset();
        step();
        chk("b_idle_valid", if_b.out_valid, 0);
        b_model(1'b0, 32'h0);
        for (int n = 1; n <= 21; n++) begin
            b_rand();
            step();
            e = scan_at(n, 4, 3);
            chk("b_scan_ch", if_b.out_ch, e);
            chk("b_scan_data", if_b.out_data, chv[e]);
            b_model(1'b1, chv[e]);
        end
        chk("b_scan_cnt", if_b.change_cnt, m_cnt);

        // Reset mid-scan at channel 2
        reset_b = 1'b1;
        step();
        chk("b_rst_data", if_b.out_data, 0);
        chk("b_rst_ch", if_b.out_ch, 0);
        chk("b_rst_valid", if_b.out_valid, 0);
        chk("b_rst_cnt", if_b.change_cnt, 0);
        reset_b = 1'b0;
        b_model_reset();
        step();
        chk("b_rel_valid", if_b.out_valid, 0);
        b_model(1'b0, 32'h0);
        for (int n = 1; n <= 5; n++) begin
            b_rand();
            step();
            e = scan_at(n, 4, 3);
            chk("b_rescan_ch", if_b.out_ch, e);
            chk("b_rescan_data", if_b.out_data, chv[e]);
            b_model(1'b1, chv[e]);
        end

        // Switch to LIVE; the change edge is still a scan output
        if_b.mode = 2'b00;
        b_rand();
        step();
        e = scan_at(6, 4, 3);
        chk("b_chg_ch", if_b.out_ch, e);
        b_model(1'b1, chv[e]);

        // Randomized LIVE / reserved mode, random select and ignored trig
        for (int k = 0; k < 60; k++) begin
            if_b.mode   = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            s           = int'($urandom_range(0, 3));
            if_b.ch_sel = 2'(s);
            if_b.trig   = 1'($urandom_range(0, 1));
            b_rand();
            step();
            e = (s < 3) ? s : 0;
            chk("b_live_ch", if_b.out_ch, e);
            chk("b_live_data", if_b.out_data, chv[e]);
            b_model(1'b1, chv[e]);
            chk("b_live_cnt", if_b.change_cnt, m_cnt);
        end
        chk("b_live_valid", if_b.out_valid, 1);
        chk("b_live_snap", if_b.snap_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
